decim_8_avg: RTL and testbench

- Decimating averager; the receive-side counterpart of the 8x sample-hold upsampler.
- Accepts a stream of signed 12-bit I/Q samples over a valid/ready handshake.
- Sums each block of DECIM consecutive accepted samples, optionally rounds, divides by DECIM and emits one averaged I/Q sample per block.
- Sits between the ADC-side sample source and the baseband demodulator.

---
 rtl/decim_8_avg.sv | 79 +++++++
 tb/tb_decim_8_avg.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decim_8_avg.sv
// Decimating I/Q averager: sums DECIM accepted samples, rounds, divides by DECIM.
// One averaged sample per block, held in a registered valid/ready output stage.
module decim_8_avg #(
    parameter int DECIM = 8,
    parameter int DW    = 12,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_i,
    output logic signed [DW-1:0] out_q
);

    localparam int L  = $clog2(DECIM);
    localparam int AW = DW + L;

    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] ext_i;
    logic signed [AW-1:0] ext_q;
    logic signed [AW-1:0] rnd;
    logic signed [AW-1:0] sum_i;
    logic signed [AW-1:0] sum_q;
    logic [L-1:0]         cnt;
    logic                 last;
    logic                 accept;
    logic                 load;

    assign last     = (cnt == L'(DECIM - 1));
    assign in_ready = !(out_valid && !out_ready && last);
    // clr wins over a concurrent handshake: the sample is consumed and dropped
    assign accept   = in_valid && in_ready && !clr;
    assign load     = accept && last;

    assign ext_i = {{L{in_i[DW-1]}}, in_i};
    assign ext_q = {{L{in_q[DW-1]}}, in_q};
    assign rnd   = (ROUND != 0) ? AW'(DECIM / 2) : '0;
    assign sum_i = acc_i + ext_i + rnd;
    assign sum_q = acc_q + ext_q + rnd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (clr || load) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (accept) begin
            acc_i <= acc_i + ext_i;
            acc_q <= acc_q + ext_q;
            cnt   <= cnt + L'(1);
        end
    end

    // Upper DW bits of the sum are the arithmetic shift by L
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_i     <= sum_i[AW-1:L];
            out_q     <= sum_q[AW-1:L];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decim_8_avg.sv
// Scoreboard bench for decim_8_avg: rounding and truncating instances.
// Directed blocks with hand-computed averages, handshake and reset checks.
module tb_decim_8_avg;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic in_valid;
    logic in_ready;
    logic signed [11:0] in_i;
    logic signed [11:0] in_q;
    logic out_ready;
    logic out_valid;
    logic signed [11:0] out_i;
    logic signed [11:0] out_q;

    logic both;
    logic in_valid0;
    logic in_ready0;
    logic out_valid0;
    logic signed [11:0] out_i0;
    logic signed [11:0] out_q0;

    typedef struct {
        int i;
        int q;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    int cmp = 0;
    int err = 0;

    always #5 clk = ~clk;

    assign in_valid0 = in_valid && both;

    decim_8_avg #(.DECIM(8), .DW(12), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_i(in_i), .in_q(in_q),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_i(out_i), .out_q(out_q)
    );

    decim_8_avg #(.DECIM(8), .DW(12), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .clr(1'b0),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_i(in_i), .in_q(in_q),
        .out_ready(1'b1), .out_valid(out_valid0),
        .out_i(out_i0), .out_q(out_q0)
    );

    function automatic void chk(input string name, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic push1(input int i, input int q);
        exp_t e;
        e.i = i;
        e.q = q;
        q1.push_back(e);
    endtask

    task automatic push0(input int i, input int q);
        exp_t e;
        e.i = i;
        e.q = q;
        q0.push_back(e);
    endtask

    task automatic send(input int i, input int q);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        in_valid = 1'b1;
        in_i = 12'(i);
        in_q = 12'(q);
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 50) begin
                chk("send_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q1.size() == 0) begin
                chk("unexpected_out_r1", int'(out_i), 9999);
            end else begin
                e = q1.pop_front();
                chk("out_i_r1", int'(out_i), e.i);
                chk("out_q_r1", int'(out_q), e.q);
            end
        end
        if (!rst && out_valid0) begin
            if (q0.size() == 0) begin
                chk("unexpected_out_r0", int'(out_i0), 9999);
            end else begin
                e = q0.pop_front();
                chk("out_i_r0", int'(out_i0), e.i);
                chk("out_q_r0", int'(out_q0), e.q);
            end
        end
    end

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
        in_i = '0;
        in_q = '0;
        out_ready = 1'b1;
        both = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_i", int'(out_i), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // ramp block
        push1(5, -4);
        for (int k = 1; k <= 8; k++) send(k, -k);
        repeat (3) @(posedge clk);
        #1;

        // full-scale blocks
        push1(2047, -2048);
        for (int k = 0; k < 8; k++) send(2047, -2048);
        push1(-2048, 2047);
        for (int k = 0; k < 8; k++) send(-2048, 2047);
        repeat (3) @(posedge clk);
        #1;

        // backpressure
        push1(10, -10);
        push1(20, -20);
        out_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            in_valid = 1'b1;
            in_i = (k < 8) ? 12'sd10 : 12'sd20;
            in_q = (k < 8) ? -12'sd10 : -12'sd20;
            @(negedge clk);
            chk($sformatf("bp_in_ready_%0d", k + 1), int'(in_ready), 1);
            @(posedge clk);
            #1;
        end
        in_i = 12'sd20;
        in_q = -12'sd20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_stall_in_ready", int'(in_ready), 0);
            chk("bp_hold_out_i", int'(out_i), 10);
            chk("bp_hold_valid", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_valid_continuous", int'(out_valid), 1);
        chk("bp_block2_i", int'(out_i), 20);
        repeat (3) @(posedge clk);
        #1;

        // clr drops partial block and the concurrent sample
        push1(16, 0);
        for (int k = 0; k < 5; k++) send(100, 0);
        clr = 1'b1;
        in_valid = 1'b1;
        in_i = 12'sd900;
        in_q = 12'sd0;
        @(negedge clk);
        chk("clr_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) send(16, 0);
        repeat (3) @(posedge clk);
        #1;

        // async reset mid-block with a pending output
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(50, 50);
        for (int k = 0; k < 3; k++) send(7, 7);
        chk("pre_rst_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_out_i", int'(out_i), 0);
        chk("async_rst_out_q", int'(out_q), 0);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        push1(8, 8);
        for (int k = 0; k < 8; k++) send(8, 8);
        repeat (3) @(posedge clk);
        #1;

        // rounding versus truncation
        both = 1'b1;
        push1(1, 0);
        push0(0, 0);
        for (int k = 0; k < 7; k++) send(0, 0);
        send(7, 0);
        push1(0, 0);
        push0(-1, 0);
        send(-1, 0);
        for (int k = 0; k < 7; k++) send(0, 0);
        repeat (4) @(posedge clk);
        #1;
        both = 1'b0;

        chk("q1_drained", q1.size(), 0);
        chk("q0_drained", q0.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
